// File: rtl/cpu_io_pkg.sv
// Shared mode encodings for the CPU IO stream bridge channels.
// A channel mode is 2 bits; the reserved code behaves as a register stage.
package cpu_io_pkg;

  localparam int CHAN_MODE_W = 2;

  localparam logic [CHAN_MODE_W-1:0] MODE_PASS = 2'b00;
  localparam logic [CHAN_MODE_W-1:0] MODE_REG  = 2'b01;
  localparam logic [CHAN_MODE_W-1:0] MODE_FIFO = 2'b10;
  localparam logic [CHAN_MODE_W-1:0] MODE_RSVD = 2'b11;

  // Folds the reserved encoding onto REG so datapath muxes see only three modes.
  function automatic logic [CHAN_MODE_W-1:0] active_mode(input logic [CHAN_MODE_W-1:0] m);
    return (m == MODE_RSVD) ? MODE_REG : m;
  endfunction

endpackage

// File: rtl/cpu_io_chan.sv
// One direction-agnostic stream channel: pass-through, 1-cycle register or
// first-word-fall-through FIFO, selected by a frame-configured mode.
module cpu_io_chan
  import cpu_io_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CHAN_MODE_W-1:0] cfg_mode,
  input  logic [W-1:0]           s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [W-1:0]           d_data,
  output logic                   d_valid,
  input  logic                   d_ready,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CHAN_MODE_W-1:0] mode_q;
  logic [CHAN_MODE_W-1:0] mode;
  logic                   flush;

  logic [W-1:0]  reg_data;
  logic          reg_valid;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic fifo_on;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  // A config change costs one dead cycle in which the old mode's state is dropped.
  assign flush = (cfg_mode != mode_q);
  assign mode  = active_mode(mode_q);

  assign fifo_on    = rst_n && !flush && (mode == MODE_FIFO);
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = fifo_on && s_valid && !fifo_full;
  assign pop        = fifo_on && !fifo_empty && d_ready;

  always_comb begin
    s_ready = 1'b0;
    d_data  = '0;
    d_valid = 1'b0;
    full    = 1'b0;
    if (rst_n && !flush) begin
      unique case (mode)
        MODE_PASS: begin
          d_data  = s_data;
          d_valid = s_valid;
          s_ready = d_ready;
        end
        MODE_FIFO: begin
          d_data  = mem[rd_ptr];
          d_valid = !fifo_empty;
          s_ready = !fifo_full;
          full    = fifo_full;
        end
        default: begin
          d_data  = reg_data;
          d_valid = reg_valid;
          s_ready = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_PASS;
      reg_data  <= '0;
      reg_valid <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else if (flush) begin
      mode_q    <= cfg_mode;
      reg_valid <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (mode == MODE_REG) begin
        reg_data  <= s_data;
        reg_valid <= s_valid;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage has no reset; stale entries are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

endmodule

// File: rtl/cpu_io_stream_bridge.sv
// CPU IO tile bridge: operand channels carry fabric->CPU, result channels CPU->fabric,
// each an independently configured cpu_io_chan.
module cpu_io_stream_bridge
  import cpu_io_pkg::*;
#(
  parameter  int NUM_OPS      = 2,
  parameter  int NUM_RES      = 3,
  parameter  int W            = 4,
  parameter  int DEPTH        = 4,
  localparam int NoConfigBits = 2 * (NUM_OPS + NUM_RES)
) (
  input  logic                       UserCLK,
  input  logic                       UserRSTn,
  input  logic [NoConfigBits-1:0]    ConfigBits,
  input  logic [NUM_OPS*W-1:0]       fab_op_data,
  input  logic [NUM_OPS-1:0]         fab_op_valid,
  output logic [NUM_OPS-1:0]         fab_op_ready,
  output logic [NUM_OPS*W-1:0]       cpu_op_data,
  output logic [NUM_OPS-1:0]         cpu_op_valid,
  input  logic [NUM_OPS-1:0]         cpu_op_ready,
  input  logic [NUM_RES*W-1:0]       cpu_res_data,
  input  logic [NUM_RES-1:0]         cpu_res_valid,
  output logic [NUM_RES-1:0]         cpu_res_ready,
  output logic [NUM_RES*W-1:0]       fab_res_data,
  output logic [NUM_RES-1:0]         fab_res_valid,
  input  logic [NUM_RES-1:0]         fab_res_ready,
  output logic [NUM_OPS+NUM_RES-1:0] chan_full
);

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    cpu_io_chan #(.W(W), .DEPTH(DEPTH)) u_chan (
      .clk      (UserCLK),
      .rst_n    (UserRSTn),
      .cfg_mode (ConfigBits[CHAN_MODE_W*i +: CHAN_MODE_W]),
      .s_data   (fab_op_data[i*W +: W]),
      .s_valid  (fab_op_valid[i]),
      .s_ready  (fab_op_ready[i]),
      .d_data   (cpu_op_data[i*W +: W]),
      .d_valid  (cpu_op_valid[i]),
      .d_ready  (cpu_op_ready[i]),
      .full     (chan_full[i])
    );
  end

  // Result channels take the config slots and full flags after the operands.
  for (genvar j = 0; j < NUM_RES; j++) begin : g_res
    cpu_io_chan #(.W(W), .DEPTH(DEPTH)) u_chan (
      .clk      (UserCLK),
      .rst_n    (UserRSTn),
      .cfg_mode (ConfigBits[CHAN_MODE_W*(NUM_OPS+j) +: CHAN_MODE_W]),
      .s_data   (cpu_res_data[j*W +: W]),
      .s_valid  (cpu_res_valid[j]),
      .s_ready  (cpu_res_ready[j]),
      .d_data   (fab_res_data[j*W +: W]),
      .d_valid  (fab_res_valid[j]),
      .d_ready  (fab_res_ready[j]),
      .full     (chan_full[NUM_OPS+j])
    );
  end

endmodule
